// File: rtl/inv_add_round_key_stage.sv
// AES-128 decryption AddRoundKey stage: XORs each state beat with the round key
// chosen by its round index, behind a single valid/ready output register.
module inv_add_round_key_stage #(
   parameter int DW  = 128,
   parameter int NR  = 10,
   parameter int RIW = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           key_wr_en,
   input  logic [RIW-1:0] key_wr_idx,
   input  logic [0:DW-1]  key_wr_data,
   output logic [NR:0]    key_loaded,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [0:DW-1]  in_state,
   input  logic [RIW-1:0] in_round,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [0:DW-1]  out_state,
   output logic [RIW-1:0] out_round,
   output logic           out_last,
   output logic           out_err
);

   localparam logic [RIW-1:0] LAST_IDX = RIW'(NR);

   logic [0:DW-1]     key_mem [0:NR];
   logic [NR:0]       key_loaded_q;
   logic [NR:0]       wr_hit;
   logic [2**RIW-1:0] loaded_ext;
   logic [RIW-1:0]    rd_idx;
   logic              key_hit;
   logic              accept;

   logic              out_valid_q, out_valid_d;
   logic [0:DW-1]     out_state_q, out_state_d;
   logic [RIW-1:0]    out_round_q, out_round_d;
   logic              out_last_q, out_last_d;
   logic              out_err_q, out_err_d;

   // One-hot write decode; indices above NR match no entry and are ignored.
   genvar gi;
   generate
      for (gi = 0; gi <= NR; gi++) begin : g_wr_hit
         assign wr_hit[gi] = key_wr_en && (key_wr_idx == RIW'(gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (key_wr_en && (key_wr_idx <= LAST_IDX)) begin
         key_mem[key_wr_idx] <= key_wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         key_loaded_q <= '0;
      end else begin
         key_loaded_q <= key_loaded_q | wr_hit;
      end
   end

   // Reads see pre-write contents, so a key written this cycle applies next cycle.
   assign loaded_ext = (2**RIW)'(key_loaded_q);
   assign key_hit    = loaded_ext[in_round];
   assign rd_idx     = (in_round <= LAST_IDX) ? in_round : '0;

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   always_comb begin
      out_valid_d = out_valid_q;
      out_state_d = out_state_q;
      out_round_d = out_round_q;
      out_last_d  = out_last_q;
      out_err_d   = out_err_q;
      if (accept) begin
         out_valid_d = 1'b1;
         out_round_d = in_round;
         out_last_d  = (in_round == '0);
         if (key_hit) begin
            out_state_d = in_state ^ key_mem[rd_idx];
            out_err_d   = 1'b0;
         end else begin
            out_state_d = in_state;
            out_err_d   = 1'b1;
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_state_q <= '0;
         out_round_q <= '0;
         out_last_q  <= 1'b0;
         out_err_q   <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         out_state_q <= out_state_d;
         out_round_q <= out_round_d;
         out_last_q  <= out_last_d;
         out_err_q   <= out_err_d;
      end
   end

   assign key_loaded = key_loaded_q;
   assign out_valid  = out_valid_q;
   assign out_state  = out_state_q;
   assign out_round  = out_round_q;
   assign out_last   = out_last_q;
   assign out_err    = out_err_q;

endmodule
